// File: rtl/alu_req_arbiter.sv
// Round-robin front end for the shared ALU: two valid/ready clients, one operation in flight.
// Latency: response 3 cycles after the request handshake when the unit flag is immediate.
// Backpressure: response held in RESP until rsp_ready; both request readies stay low while busy.
module alu_req_arbiter #(
    parameter int In_Data_Width = 8,
    parameter int Out_Width     = 2 * In_Data_Width,
    parameter int Timeout       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [In_Data_Width-1:0] req0_a,
    input  logic [In_Data_Width-1:0] req0_b,
    input  logic [3:0]               req0_func,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [In_Data_Width-1:0] req1_a,
    input  logic [In_Data_Width-1:0] req1_b,
    input  logic [3:0]               req1_func,
    output logic [In_Data_Width-1:0] alu_a,
    output logic [In_Data_Width-1:0] alu_b,
    output logic [3:0]               alu_func,
    input  logic [Out_Width-1:0]     alu_arith_out,
    input  logic [In_Data_Width-1:0] alu_logic_out,
    input  logic [In_Data_Width-1:0] alu_shift_out,
    input  logic [1:0]               alu_cmp_out,
    input  logic                     alu_arith_flag,
    input  logic                     alu_logic_flag,
    input  logic                     alu_cmp_flag,
    input  logic                     alu_shift_flag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [Out_Width-1:0]     rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int                   Cnt_Width = $clog2(Timeout + 1);
    localparam logic [Cnt_Width-1:0] Cnt_Max   = Cnt_Width'(Timeout);

    state_t               state;
    logic                 last_id;
    logic                 cur_id;
    logic                 grant;
    logic                 hs;
    logic                 sel_flag;
    logic [Cnt_Width-1:0] wait_cnt;
    logic [Out_Width-1:0] merged;

    // A lone requester wins outright; a tie goes to the one not served last.
    always_comb begin
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else begin
            grant = ~last_id;
        end
    end

    assign req0_ready = rst && (state == IDLE) && !grant;
    assign req1_ready = rst && (state == IDLE) && grant;
    assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign busy       = (state != IDLE);

    always_comb begin
        sel_flag = 1'b0;
        merged   = '0;
        case (alu_func[3:2])
            2'b00: begin
                sel_flag = alu_arith_flag;
                merged   = alu_arith_out;
            end
            2'b01: begin
                sel_flag                      = alu_logic_flag;
                merged[In_Data_Width-1:0]     = alu_logic_out;
            end
            2'b10: begin
                sel_flag    = alu_cmp_flag;
                merged[1:0] = alu_cmp_out;
            end
            default: begin
                sel_flag                      = alu_shift_flag;
                merged[In_Data_Width-1:0]     = alu_shift_out;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_id   <= 1'b1;
            cur_id    <= 1'b0;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        cur_id   <= grant;
                        last_id  <= grant;
                        alu_a    <= grant ? req1_a : req0_a;
                        alu_b    <= grant ? req1_b : req0_b;
                        alu_func <= grant ? req1_func : req0_func;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A flag arriving on the last allowed cycle still beats the timeout.
                    if (sel_flag) begin
                        rsp_data  <= merged;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == Cnt_Max) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester front end for the shared signed ALU top. The block accepts operation requests (A, B, 4-bit ALU function) from two clients over valid/ready handshakes, arbitrates round-robin, and drives the ALU operand and function inputs from registers. It waits for the flag of the selected unit, merges the four unit outputs into one response word, and returns that word to the granted client with a requester ID and an error bit.

## Interface
Parameters:
- In_Data_Width, 8, operand width; must match the ALU instance.
- Out_Width, 2*In_Data_Width, response data width; equals the ALU arithmetic output width.
- Timeout, 4, maximum cycles spent in WAIT before an error response; must be at least 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  In_Data_Width  operands, two's complement.
- req0_func / req1_func  in  4  ALU function; [3:2] selects the unit: 00 arith, 01 logic, 10 cmp, 11 shift.
- alu_a, alu_b  out  In_Data_Width  registered operands to the ALU.
- alu_func  out  4  registered function to the ALU.
- alu_arith_out  in  Out_Width  ALU arithmetic result.
- alu_logic_out  in  In_Data_Width  ALU logic result.
- alu_shift_out  in  In_Data_Width  ALU shift result.
- alu_cmp_out  in  2  ALU compare result.
- alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag  in  1 each  unit result-valid flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  Out_Width  merged result.
- rsp_err  out  1  timeout; rsp_data is 0 when set.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and equals IDLE & grant==N.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - On handshake: capture a, b, func and the ID into the alu_* registers and the ID register, update the pointer, go to ISSUE.
- ISSUE: one cycle while the ALU registers its inputs. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Each cycle, sample the flag selected by alu_func[3:2].
  - Flag high: capture the merged result, set rsp_err=0, go to RESP.
  - Flag low: increment the counter. When the counter reaches Timeout, set rsp_data=0 and rsp_err=1, then go to RESP.
- RESP: hold rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_ready is high, then go to IDLE.
- Merge rule:
  - arith: alu_arith_out unchanged.
  - logic and shift: zero-extended to Out_Width.
  - cmp: zero-extended 2-bit code.
- alu_a, alu_b and alu_func hold the last captured values outside IDLE-capture. The ALU's outputs for other units are ignored.
- Only one transaction is in flight. Both ready outputs are 0 in every state except IDLE.

## Timing
- Reset (rst low, asynchronous): state=IDLE, pointer=1, all outputs 0 (ready outputs follow IDLE and the valids combinationally), counter 0.
- Nominal latency with handshake in cycle T:
  - ISSUE in T+1.
  - ALU outputs and flag valid in T+2 (WAIT).
  - rsp_valid first high in T+3.
- Minimum request-to-request spacing is 4 cycles. The next reqN_ready can go high in the cycle after rsp_valid&rsp_ready.
- Timeout path: rsp_valid is first high in T+2+Timeout+1.
- Simultaneous valids in IDLE: exactly one ready is high. The loser's valid and data must be held by the client (standard valid/ready rule).
- A request whose valid rises while the block is busy waits. It is not dropped.
- rsp_ready high at the first RESP cycle gives a 1-cycle response. rsp_ready low stalls indefinitely with the response held.
- rst asserted mid-transaction: the transaction is discarded, no response is produced, and outputs return to reset values immediately.

## Test plan
- Reset: drive rst low for 3 cycles with both valids high -> all outputs 0, no handshake. After release, req0_ready=1 in the first IDLE cycle.
- Single arith op: req0 with a=8'sd5, b=-8'sd3, func=4'b0000 (add) -> rsp_valid at T+3 with rsp_id=0, rsp_data=16'h0002, rsp_err=0.
- Tie, round-robin: both valid from reset, with req1 using func=4'b0100 (AND), a=8'hF0, b=8'h3C -> req0 served first. Then req1: rsp_id=1, rsp_data=16'h0030. A third tie grants req0 again.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, busy=1, both ready outputs 0. Release -> IDLE next cycle.
- Timeout: force the selected flag low, Timeout=4 -> rsp_err=1 and rsp_data=0 at T+7.
- Reset mid-WAIT: pull rst low in T+2 -> no rsp_valid. After release, a new req1 completes normally.
